vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares the single 64-bit PVR VRAM port between three requesters: display fetch (0), PVR core (1),
//  SH4 CS1 accesses (2). Sits between pvr and the VRAM controller. Arbitrates, issues one access at a time,
//  and routes read data back in order.
// PARAMETERS
//  ADDR_W    24  VRAM address width (64-bit word address on the VRAM side)
//  DATA_W    64  VRAM data width
//  DISP_MAX   4  max consecutive display grants while another requester is pending
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous, active-high reset
//  req          in   3           per-requester request; held with fields stable until gnt
//  req_we       in   3           1=write, 0=read
//  req_addr     in   3*ADDR_W    packed addresses, slice i = requester i
//  req_wdata    in   3*DATA_W    packed write data
//  req_wmask    in   3*8         packed byte enables (writes only)
//  gnt          out  3           one-hot 1-cycle pulse: access issued to VRAM this cycle
//  rvalid       out  3           one-hot 1-cycle pulse: rdata valid for that requester
//  rdata        out  DATA_W      read data, shared by all requesters
//  vram_rd      out  1           VRAM read strobe
//  vram_wr      out  1           VRAM write strobe
//  vram_addr    out  ADDR_W      VRAM address
//  vram_dout    out  DATA_W      VRAM write data
//  vram_wmask   out  8           VRAM byte enables
//  vram_busy    in   1           VRAM cannot accept a strobe this cycle
//  vram_rvalid  in   1           VRAM read data return pulse
//  vram_din     in   DATA_W      VRAM read data
// BEHAVIOUR
//  - One clock, clk; rst synchronous active-high. On reset: all outputs 0, FSM=IDLE, rr_ptr=1, disp_cnt=0.
//  - FSM: IDLE -> (any req && !vram_busy) ISSUE; ISSUE -> write: IDLE; read: WAIT_RD; WAIT_RD -> (vram_rvalid) IDLE.
//  - Grant decision made combinationally in IDLE; gnt, vram_rd/vram_wr, vram_addr/dout/wmask registered,
//    all asserted in the ISSUE cycle (1 cycle after decision). Strobes are single-cycle.
//  - Priority: display (0) wins unless disp_cnt==DISP_MAX and req[1]|req[2]; then round-robin 1/2 wins.
//    disp_cnt increments per display grant, clears on any non-display grant or when req[2:1]==0.
//  - Requesters 1/2 round-robin: rr_ptr points to preferred one; after granting k, rr_ptr = other.
//  - Only one read outstanding; no new issue in WAIT_RD. rdata <= vram_din and rvalid[owner] pulse the
//    cycle after vram_rvalid. Best-case read: req->gnt 1 cycle, gnt->rvalid = VRAM latency + 1.
//  - Write completes at gnt; no rvalid for writes. Back-to-back writes: one per 2 cycles (IDLE,ISSUE).
//  - vram_busy high in IDLE holds FSM in IDLE; no gnt, no strobe. vram_busy ignored in other states.
//  - vram_rvalid outside WAIT_RD is ignored (no rvalid pulse).
//  - Requester dropping req before gnt: legal, its slot is simply not granted.
//  - rst during WAIT_RD: pending read discarded, no rvalid; late vram_rvalid after reset ignored.
//  - Address/data widths pass through unchanged; no address translation (done upstream in pvr).
// CONFIGURATION
//  VRAM_ARB_PERF_EN defined: adds perf_grants[3*32] out (grant counts per requester) and perf_wait[3*32]
//   out (cycles req high without gnt); 32-bit saturating, cleared by rst.
//  Undefined: counters and ports absent; arbitration identical.
// STRUCTURE
//  Shared package vram_pkg: VRAM_ADDR_W/VRAM_DATA_W, requester index constants REQ_DISP=0/REQ_PVR=1/REQ_CPU=2,
//   FSM state enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD}.
//  One sub-module: vram_arb_pick (combinational priority + round-robin select; in req, disp_cnt, rr_ptr;
//   out one-hot winner). Datapath muxing and FSM stay in vram_arbiter.
// TESTING
//  1. Single CPU read addr 24'h000100, VRAM returns 64'hDEADBEEF_CAFEF00D after 3 cycles -> gnt[2] 1 cycle
//     after req, vram_rd with vram_addr=24'h000100, rvalid[2] with that rdata, nothing else pulses.
//  2. req=3'b111 continuously, all writes -> grant order 0,0,0,0,1,0,0,0,0,2,... (DISP_MAX=4), rr alternates 1/2.
//  3. req=3'b110, writes -> gnt alternates 1,2,1,2; exactly one gnt every 2 cycles, disp_cnt stays 0.
//  4. vram_busy held high 10 cycles with req[1]=1 -> no gnt/strobe; gnt[1] one cycle after busy drops.
//  5. rst asserted during WAIT_RD, vram_rvalid arrives 2 cycles later -> no rvalid, all outputs 0, FSM IDLE.
//  6. Write req[0] addr 24'h7FFFFF wmask 8'h0F -> vram_wr 1 cycle, vram_wmask=8'h0F, no rvalid ever.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM widths, requester indices and arbiter state type
package vram_pkg;

    localparam int VRAM_ADDR_W = 24;
    localparam int VRAM_DATA_W = 64;

    localparam logic [1:0] REQ_DISP = 2'd0;
    localparam logic [1:0] REQ_PVR  = 2'd1;
    localparam logic [1:0] REQ_CPU  = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT_RD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and VRAM-side signals of the VRAM arbiter
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) ();

    logic [2:0]          req;
    logic [2:0]          req_we;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_wdata;
    logic [3*8-1:0]      req_wmask;
    logic [2:0]          gnt;
    logic [2:0]          rvalid;
    logic [DATA_W-1:0]   rdata;

    logic                vram_rd;
    logic                vram_wr;
    logic [ADDR_W-1:0]   vram_addr;
    logic [DATA_W-1:0]   vram_dout;
    logic [7:0]          vram_wmask;
    logic                vram_busy;
    logic                vram_rvalid;
    logic [DATA_W-1:0]   vram_din;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_wmask,
        input  vram_busy, vram_rvalid, vram_din,
        output gnt, rvalid, rdata,
        output vram_rd, vram_wr, vram_addr, vram_dout, vram_wmask
    );

    modport master (
        output req, req_we, req_addr, req_wdata, req_wmask,
        output vram_busy, vram_rvalid, vram_din,
        input  gnt, rvalid, rdata,
        input  vram_rd, vram_wr, vram_addr, vram_dout, vram_wmask
    );

endinterface

// File: rtl/vram_arb_pick.sv
// rtl/vram_arb_pick.sv - combinational winner select: display priority with a
// consecutive-grant cap, round-robin between PVR and CPU
module vram_arb_pick
    import vram_pkg::*;
#(
    parameter int DISP_MAX = 4,
    parameter int CNT_W    = $clog2(DISP_MAX + 1)
) (
    input  logic [2:0]       req,
    input  logic [CNT_W-1:0] disp_cnt,
    input  logic [1:0]       rr_ptr,
    output logic [2:0]       winner
);

    logic disp_capped;

    assign disp_capped = (disp_cnt == CNT_W'(DISP_MAX)) && (req[REQ_PVR] || req[REQ_CPU]);

    always_comb begin
        winner = '0;
        if (req[REQ_DISP] && !disp_capped) begin
            winner[REQ_DISP] = 1'b1;
        end else if (req[REQ_PVR] && req[REQ_CPU]) begin
            winner[(rr_ptr == REQ_CPU) ? REQ_CPU : REQ_PVR] = 1'b1;
        end else if (req[REQ_PVR]) begin
            winner[REQ_PVR] = 1'b1;
        end else if (req[REQ_CPU]) begin
            winner[REQ_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares the 64-bit VRAM port between display, PVR core and CPU;
// one access in flight, in-order read return. Optional counters under VRAM_ARB_PERF_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int DISP_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    vram_arbiter_if.slave  bus
`ifdef VRAM_ARB_PERF_EN
    ,
    output logic [3*32-1:0] perf_grants,
    output logic [3*32-1:0] perf_wait
`endif
);

    localparam int CNT_W = $clog2(DISP_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              vram_rd_q, vram_rd_d;
    logic              vram_wr_q, vram_wr_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_dout_q, vram_dout_d;
    logic [7:0]        vram_wmask_q, vram_wmask_d;
    logic [2:0]        owner_q, owner_d;
    logic [CNT_W-1:0]  disp_cnt_q, disp_cnt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        winner;

    vram_arb_pick #(
        .DISP_MAX (DISP_MAX),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req      (bus.req),
        .disp_cnt (disp_cnt_q),
        .rr_ptr   (rr_ptr_q),
        .winner   (winner)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = '0;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        vram_rd_d    = 1'b0;
        vram_wr_d    = 1'b0;
        vram_addr_d  = '0;
        vram_dout_d  = '0;
        vram_wmask_d = '0;
        owner_d      = owner_q;
        disp_cnt_d   = disp_cnt_q;
        rr_ptr_d     = rr_ptr_q;

        case (state_q)
            ARB_IDLE: begin
                if ((|bus.req) && !bus.vram_busy) begin
                    state_d = ARB_ISSUE;
                    gnt_d   = winner;
                    owner_d = winner;
                    for (int i = 0; i < 3; i++) begin
                        if (winner[i]) begin
                            vram_rd_d    = ~bus.req_we[i];
                            vram_wr_d    = bus.req_we[i];
                            vram_addr_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
                            vram_dout_d  = bus.req_wdata[i*DATA_W +: DATA_W];
                            vram_wmask_d = bus.req_wmask[i*8 +: 8];
                        end
                    end
                    if (winner[REQ_DISP]) begin
                        if (disp_cnt_q != CNT_W'(DISP_MAX)) begin
                            disp_cnt_d = disp_cnt_q + 1'b1;
                        end
                    end else begin
                        disp_cnt_d = '0;
                    end
                    if (winner[REQ_PVR]) begin
                        rr_ptr_d = REQ_CPU;
                    end else if (winner[REQ_CPU]) begin
                        rr_ptr_d = REQ_PVR;
                    end
                end
            end
            ARB_ISSUE: begin
                state_d = vram_rd_q ? ARB_WAIT_RD : ARB_IDLE;
            end
            ARB_WAIT_RD: begin
                if (bus.vram_rvalid) begin
                    rdata_d  = bus.vram_din;
                    rvalid_d = owner_q;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // The display cap only matters while someone else is waiting.
        if (bus.req[REQ_CPU:REQ_PVR] == 2'b00) begin
            disp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            vram_rd_q    <= 1'b0;
            vram_wr_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_dout_q  <= '0;
            vram_wmask_q <= '0;
            owner_q      <= '0;
            disp_cnt_q   <= '0;
            rr_ptr_q     <= REQ_PVR;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            vram_rd_q    <= vram_rd_d;
            vram_wr_q    <= vram_wr_d;
            vram_addr_q  <= vram_addr_d;
            vram_dout_q  <= vram_dout_d;
            vram_wmask_q <= vram_wmask_d;
            owner_q      <= owner_d;
            disp_cnt_q   <= disp_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.vram_rd    = vram_rd_q;
    assign bus.vram_wr    = vram_wr_q;
    assign bus.vram_addr  = vram_addr_q;
    assign bus.vram_dout  = vram_dout_q;
    assign bus.vram_wmask = vram_wmask_q;

`ifdef VRAM_ARB_PERF_EN
    logic [31:0] perf_grants_q [3];
    logic [31:0] perf_grants_d [3];
    logic [31:0] perf_wait_q   [3];
    logic [31:0] perf_wait_d   [3];

    always_comb begin
        perf_grants_d = perf_grants_q;
        perf_wait_d   = perf_wait_q;
        for (int i = 0; i < 3; i++) begin
            if (gnt_q[i] && (perf_grants_q[i] != '1)) begin
                perf_grants_d[i] = perf_grants_q[i] + 32'd1;
            end
            if (bus.req[i] && !gnt_q[i] && (perf_wait_q[i] != '1)) begin
                perf_wait_d[i] = perf_wait_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                perf_grants_q[i] <= '0;
                perf_wait_q[i]   <= '0;
            end
        end else begin
            perf_grants_q <= perf_grants_d;
            perf_wait_q   <= perf_wait_d;
        end
    end

    always_comb begin
        perf_grants = '0;
        perf_wait   = '0;
        for (int i = 0; i < 3; i++) begin
            perf_grants[i*32 +: 32] = perf_grants_q[i];
            perf_wait[i*32 +: 32]   = perf_wait_q[i];
        end
    end
`endif

endmodule
